// File: rtl/ram_burst_ctrl_if.sv
// Stream-side bundle of the RAM burst controller: command, write-data and
// read-data valid/ready channels.
interface ram_burst_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wdata_valid;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ready;

    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              rdata_ready;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len,
        output wdata_valid, wdata,
        output rdata_ready,
        input  cmd_ready, wdata_ready, rdata_valid, rdata
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
        input  wdata_valid, wdata,
        input  rdata_ready,
        output cmd_ready, wdata_ready, rdata_valid, rdata
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst sequencer for a 1K x 8 single-port RAM; every RAM pin is registered so
// address and data stay put for the whole chip-select window.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for a command, cmd_ready high
//   W_WAIT   | write burst, waiting for the next write beat (cs/wr low)
//   W_STROBE | single cycle with cs = wr = 1 for the captured beat
//   R_ADDR   | cs high, wr low, address stable; RAM output captured at the end
//   R_HOLD   | read beat presented until the consumer takes it
//   DONE     | done pulse, back to IDLE next cycle
module ram_burst_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    ram_burst_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_din,
    input  logic [DATA_W-1:0]  ram_dout,
    output logic               ram_wr,
    output logic               ram_cs,
    output logic               busy,
    output logic               done
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_WAIT   = 3'd1,
        W_STROBE = 3'd2,
        R_ADDR   = 3'd3,
        R_HOLD   = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  remaining_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_nxt;
    logic              rvalid_q;
    logic              rvalid_nxt;
    logic              cs_nxt;
    logic              wr_nxt;
    logic              done_nxt;
    logic              last_beat;

    assign last_beat = (remaining == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_cs    <= 1'b0;
            ram_wr    <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            ram_addr  <= addr_nxt;
            ram_din   <= din_nxt;
            ram_cs    <= cs_nxt;
            ram_wr    <= wr_nxt;
            rdata_q   <= rdata_nxt;
            rvalid_q  <= rvalid_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.cmd_valid) state_nxt = bus.cmd_wr ? W_WAIT : R_ADDR;
            W_WAIT:   if (bus.wdata_valid) state_nxt = W_STROBE;
            W_STROBE: state_nxt = last_beat ? DONE : W_WAIT;
            R_ADDR:   state_nxt = R_HOLD;
            R_HOLD:   if (bus.rdata_ready) state_nxt = last_beat ? DONE : R_ADDR;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Next values of the registered RAM pins and read channel; default is hold.
    always_comb begin
        addr_nxt      = ram_addr;
        din_nxt       = ram_din;
        cs_nxt        = ram_cs;
        wr_nxt        = ram_wr;
        remaining_nxt = remaining;
        rdata_nxt     = rdata_q;
        rvalid_nxt    = rvalid_q;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                cs_nxt = 1'b0;
                wr_nxt = 1'b0;
                if (bus.cmd_valid) begin
                    addr_nxt      = bus.cmd_addr;
                    remaining_nxt = bus.cmd_len;
                    cs_nxt        = ~bus.cmd_wr;
                end
            end
            W_WAIT: begin
                cs_nxt = bus.wdata_valid;
                wr_nxt = bus.wdata_valid;
                if (bus.wdata_valid) din_nxt = bus.wdata;
            end
            W_STROBE: begin
                cs_nxt = 1'b0;
                wr_nxt = 1'b0;
                if (last_beat) begin
                    done_nxt = 1'b1;
                end else begin
                    addr_nxt      = ram_addr + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                end
            end
            R_ADDR: begin
                rdata_nxt  = ram_dout;
                rvalid_nxt = 1'b1;
            end
            R_HOLD: begin
                // cs stays high between beats of one read burst
                if (bus.rdata_ready) begin
                    rvalid_nxt = 1'b0;
                    if (last_beat) begin
                        cs_nxt   = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        addr_nxt      = ram_addr + 1'b1;
                        remaining_nxt = remaining - 1'b1;
                    end
                end
            end
            DONE: begin
                cs_nxt = 1'b0;
                wr_nxt = 1'b0;
            end
            default: begin
                cs_nxt     = 1'b0;
                wr_nxt     = 1'b0;
                rvalid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.wdata_ready = (state == W_WAIT);
    assign bus.rdata_valid = rvalid_q;
    assign bus.rdata       = rdata_q;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural RAM plus a flat reference memory image,
// directed and random bursts with exact cycle-level pin checks.
module tb_ram_burst_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_wr;
    logic              ram_cs;
    logic              busy;
    logic              done;

    ram_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    ram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_wr   (ram_wr),
        .ram_cs   (ram_cs),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: write on the clock edge, asynchronous read.
    logic [7:0] ram_mem [DEPTH] = '{default: 8'h00};
    always @(posedge clk) if (ram_cs === 1'b1 && ram_wr === 1'b1) ram_mem[ram_addr] <= ram_din;
    assign ram_dout = (ram_cs && !ram_wr) ? ram_mem[ram_addr] : 8'h00;

    logic [7:0] mem_ref [DEPTH];
    logic [7:0] wq [$];
    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (ram_wr === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    function automatic logic [9:0] wa(input int a);
        return 10'(a % DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input int addr, input int len);
        int guard;
        guard = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = wa(addr);
        bus.cmd_len   = 8'(len);
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("cmd_accept_in_time", 32'(guard < 50), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("busy_after_cmd", 32'(busy), 1);
    endtask

    task automatic do_write(input int addr, input int len, input int gmin, input int gmax,
                            input logic lock);
        logic [7:0] d;
        int gap, d0, w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        send_cmd(1'b1, addr, len);
        for (int i = 0; i <= len; i++) begin
            d   = wq.pop_front();
            gap = $urandom_range(gmax, gmin);
            repeat (gap) begin
                @(posedge clk); #1;
                check("w_gap_pins_idle", 32'({ram_cs, ram_wr}), 0);
            end
            if (lock) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_wr    = 1'b1;
                bus.cmd_addr  = 10'd512;
                bus.cmd_len   = 8'd0;
                check("lock_cmd_ready", 32'(bus.cmd_ready), 0);
            end
            bus.wdata_valid = 1'b1;
            bus.wdata       = d;
            check("w_ready", 32'(bus.wdata_ready), 1);
            @(posedge clk); #1;
            // valid stays high with junk data through the strobe; it must not be taken
            bus.wdata = ~d;
            check("w_strobe_pins", 32'({ram_cs, ram_wr}), 3);
            check("w_strobe_addr", 32'(ram_addr), 32'(wa(addr + i)));
            check("w_strobe_din", 32'(ram_din), 32'(d));
            check("w_strobe_no_ready", 32'(bus.wdata_ready), 0);
            @(posedge clk); #1;
            bus.wdata_valid = 1'b0;
            check("w_strobe_end", 32'({ram_cs, ram_wr}), 0);
            check("w_din_stable", 32'(ram_din), 32'(d));
            mem_ref[wa(addr + i)] = d;
        end
        check("w_done_pulse", 32'(done), 1);
        check("w_done_cmd_ready", 32'(bus.cmd_ready), 0);
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("w_done_cleared", 32'({done, busy}), 0);
        check("w_idle_cmd_ready", 32'(bus.cmd_ready), 1);
        check("w_done_count", 32'(done_cnt - d0), 1);
        check("w_wr_cycles", 32'(wr_cnt - w0), 32'(len + 1));
    endtask

    task automatic do_read(input int addr, input int len, input int smin, input int smax,
                           input int abort_at);
        logic [7:0] exp;
        int stall, d0, w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        send_cmd(1'b0, addr, len);
        check("r_first_no_valid", 32'(bus.rdata_valid), 0);
        for (int i = 0; i <= len; i++) begin
            exp = mem_ref[wa(addr + i)];
            check("r_addr_phase_pins", 32'({ram_cs, ram_wr}), 2);
            check("r_addr", 32'(ram_addr), 32'(wa(addr + i)));
            @(posedge clk); #1;
            check("r_valid", 32'(bus.rdata_valid), 1);
            check("r_data", 32'(bus.rdata), 32'(exp));
            if (i == abort_at) begin
                #3 rst = 1'b1;
                #1;
                check("rst_pins_low", 32'({ram_cs, ram_wr, bus.rdata_valid, done, busy}), 0);
                check("rst_rdata_zero", 32'(bus.rdata), 0);
                check("rst_addr_zero", 32'(ram_addr), 0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(posedge clk); #1;
                check("rst_no_done", 32'(done_cnt - d0), 0);
                check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
                return;
            end
            stall = $urandom_range(smax, smin);
            repeat (stall) begin
                @(posedge clk); #1;
                check("r_hold_valid", 32'(bus.rdata_valid), 1);
                check("r_hold_data", 32'(bus.rdata), 32'(exp));
                check("r_hold_cs", 32'(ram_cs), 1);
            end
            bus.rdata_ready = 1'b1;
            @(posedge clk); #1;
            bus.rdata_ready = 1'b0;
            check("r_valid_drop", 32'(bus.rdata_valid), 0);
        end
        check("r_done_pulse", 32'(done), 1);
        check("r_cs_released", 32'(ram_cs), 0);
        @(posedge clk); #1;
        check("r_done_cleared", 32'({done, busy}), 0);
        check("r_done_count", 32'(done_cnt - d0), 1);
        check("r_no_writes", 32'(wr_cnt - w0), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, n;
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_wr      = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;
        foreach (mem_ref[i]) mem_ref[i] = 8'h00;

        @(posedge clk); #1;
        check("reset_pins", 32'({ram_cs, ram_wr, bus.rdata_valid, done, busy}), 0);
        check("reset_addr_din", 32'({ram_addr, ram_din}), 0);
        check("reset_rdata", 32'(bus.rdata), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_cmd_ready", 32'(bus.cmd_ready), 1);
        check("reset_wdata_ready", 32'(bus.wdata_ready), 0);

        // single write and read-back
        wq = '{8'hFF};
        do_write(32, 0, 0, 0, 1'b0);
        check("mem32", 32'(ram_mem[32]), 32'h0FF);
        do_read(32, 0, 0, 0, -1);

        // burst with write gaps and three-cycle read backpressure
        wq = '{8'hAC, 8'h9B, 8'h8F, 8'h7F};
        do_write(64, 3, 1, 3, 1'b0);
        check("mem64", 32'({ram_mem[64], ram_mem[65], ram_mem[66], ram_mem[67]}), 32'hAC9B8F7F);
        do_read(64, 3, 3, 3, -1);

        // wrap past the top of the address space
        wq = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_write(1022, 3, 0, 1, 1'b0);
        check("mem_wrap", 32'({ram_mem[1022], ram_mem[1023], ram_mem[0], ram_mem[1]}), 32'h01020304);
        do_read(1022, 3, 0, 2, -1);

        // command to 512 held up during a busy write burst is ignored
        wq = '{8'h5A, 8'hA5};
        do_write(100, 1, 0, 2, 1'b1);
        check("lock_mem512", 32'(ram_mem[512]), 0);

        // random bursts
        for (int k = 0; k < 12; k++) begin
            a = $urandom_range(DEPTH - 1, 0);
            n = $urandom_range(7, 0);
            for (int j = 0; j <= n; j++) wq.push_back(8'($urandom));
            do_write(a, n, 0, 2, 1'b0);
            do_read(a, n, 0, 3, -1);
        end
        for (int k = 0; k < 3; k++) begin
            do_read($urandom_range(DEPTH - 1, 0), $urandom_range(5, 0), 0, 2, -1);
        end

        // longest burst, wrapping
        for (int j = 0; j < 256; j++) wq.push_back(8'($urandom));
        do_write(900, 255, 0, 0, 1'b0);
        do_read(900, 255, 0, 1, -1);

        // reset in the middle of a read burst, then a clean read
        do_read(256, 7, 0, 1, 2);
        do_read(256, 0, 0, 0, -1);

        for (int i = 0; i < DEPTH; i++) check("mem_sweep", 32'(ram_mem[i]), 32'(mem_ref[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
